ddr_axi_burst_master: RTL and testbench

- Synthesizable AXI4 burst initiator that drives the DDR slave port (DDR_SLAVE_* channels) on behalf of one local client.
- Accepts one command at a time (write or read, address, length, ID). Streams write data from a local input FIFO interface and returns read data on a local output stream.
- Reports per-transaction completion and sticky error status. Sits between test/DMA logic and the DDR AXI slave, in the DDR slave clock domain.

---
 rtl/ddr_axi_burst_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_ddr_axi_burst_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ddr_axi_burst_master
// Brief    : Single-outstanding AXI4 burst initiator for the DDR slave port.
// Revision : 1.0 - initial release
// ============================================================================

module ddr_axi_burst_master #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [1:0]  BURST_TYPE     = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [3:0]  cmd_id,

    input  logic [31:0] wdata_in,
    input  logic        wdata_valid,
    output logic        wdata_ready,

    output logic [31:0] rdata_out,
    output logic        rdata_last,
    output logic        rdata_valid,
    input  logic        rdata_ready,

    output logic        done,
    output logic [1:0]  done_resp,
    output logic        err_resp,
    output logic        err_timeout,
    input  logic        err_clr,

    output logic [3:0]  M_WR_ADDR_ID,
    output logic [31:0] M_WR_ADDR,
    output logic [7:0]  M_WR_ADDR_LEN,
    output logic [1:0]  M_WR_ADDR_BURST,
    output logic        M_WR_ADDR_VALID,
    input  logic        M_WR_ADDR_READY,
    output logic [31:0] M_WR_DATA,
    output logic [3:0]  M_WR_STRB,
    output logic        M_WR_DATA_LAST,
    output logic        M_WR_DATA_VALID,
    input  logic        M_WR_DATA_READY,
    input  logic [3:0]  M_WR_BACK_ID,
    input  logic [1:0]  M_WR_BACK_RESP,
    input  logic        M_WR_BACK_VALID,
    output logic        M_WR_BACK_READY,

    output logic [3:0]  M_RD_ADDR_ID,
    output logic [31:0] M_RD_ADDR,
    output logic [7:0]  M_RD_ADDR_LEN,
    output logic [1:0]  M_RD_ADDR_BURST,
    output logic        M_RD_ADDR_VALID,
    input  logic        M_RD_ADDR_READY,
    input  logic [3:0]  M_RD_BACK_ID,
    input  logic [31:0] M_RD_DATA,
    input  logic [1:0]  M_RD_DATA_RESP,
    input  logic        M_RD_DATA_LAST,
    input  logic        M_RD_DATA_VALID,
    output logic        M_RD_DATA_READY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int unsigned          c_wait_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wait_w-1:0]  c_wait_max = c_wait_w'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [3:0]          id_q, id_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [1:0]          resp_acc_q, resp_acc_d;
    logic [1:0]          done_resp_q, done_resp_d;
    logic                awvalid_q, awvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                done_q, done_d;
    logic                err_resp_q, err_resp_d;
    logic                err_timeout_q, err_timeout_d;
    logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_last_beat;
    logic w_waiting, w_resp_err, w_timeout_hit;

    assign w_last_beat = (beat_cnt_q == len_q);
    assign w_aw_hs     = awvalid_q && M_WR_ADDR_READY;
    assign w_ar_hs     = arvalid_q && M_RD_ADDR_READY;
    assign w_w_hs      = (state_q == WR_DATA) && wdata_valid && M_WR_DATA_READY;
    assign w_r_hs      = (state_q == RD_DATA) && M_RD_DATA_VALID && rdata_ready;
    assign w_waiting   = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == WR_RESP)
                      || (state_q == RD_ADDR) || (state_q == RD_DATA);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        id_d          = id_q;
        beat_cnt_d    = beat_cnt_q;
        resp_acc_d    = resp_acc_q;
        done_resp_d   = done_resp_q;
        w_resp_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    id_d       = cmd_id;
                    beat_cnt_d = 8'd0;
                    resp_acc_d = 2'b00;
                    state_d    = cmd_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (w_aw_hs) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (w_w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_WR_BACK_VALID) begin
                    resp_acc_d = M_WR_BACK_RESP;
                    w_resp_err = (M_WR_BACK_RESP != 2'b00) || (M_WR_BACK_ID != id_q);
                    state_d    = DONE;
                end
            end
            RD_ADDR: begin
                if (w_ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (w_r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (M_RD_DATA_RESP > resp_acc_q) resp_acc_d = M_RD_DATA_RESP;
                    // The local beat count decides the exit; a slave LAST disagreement is only flagged.
                    w_resp_err = (M_RD_DATA_RESP != 2'b00) || (M_RD_BACK_ID != id_q)
                              || (M_RD_DATA_LAST != w_last_beat);
                    if (w_last_beat) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        awvalid_d = (state_d == WR_ADDR);
        arvalid_d = (state_d == RD_ADDR);
        done_d    = (state_d == DONE);
        if (state_d == DONE) done_resp_d = resp_acc_d;

        // Stall counter restarts on any progress so it measures one wait state only.
        if (!w_waiting || (state_d != state_q) || w_aw_hs || w_w_hs || w_ar_hs || w_r_hs) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != c_wait_max) begin
            wait_cnt_d = wait_cnt_q + c_wait_w'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        w_timeout_hit = (wait_cnt_q != c_wait_max) && (wait_cnt_d == c_wait_max);

        if (w_resp_err)   err_resp_d = 1'b1;
        else if (err_clr) err_resp_d = 1'b0;
        else              err_resp_d = err_resp_q;

        if (w_timeout_hit) err_timeout_d = 1'b1;
        else if (err_clr)  err_timeout_d = 1'b0;
        else               err_timeout_d = err_timeout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= 32'd0;
            len_q         <= 8'd0;
            id_q          <= 4'd0;
            beat_cnt_q    <= 8'd0;
            resp_acc_q    <= 2'b00;
            done_resp_q   <= 2'b00;
            awvalid_q     <= 1'b0;
            arvalid_q     <= 1'b0;
            done_q        <= 1'b0;
            err_resp_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            id_q          <= id_d;
            beat_cnt_q    <= beat_cnt_d;
            resp_acc_q    <= resp_acc_d;
            done_resp_q   <= done_resp_d;
            awvalid_q     <= awvalid_d;
            arvalid_q     <= arvalid_d;
            done_q        <= done_d;
            err_resp_q    <= err_resp_d;
            err_timeout_q <= err_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready       = (state_q == IDLE);

    assign M_WR_ADDR_ID    = id_q;
    assign M_WR_ADDR       = addr_q;
    assign M_WR_ADDR_LEN   = len_q;
    assign M_WR_ADDR_BURST = BURST_TYPE;
    assign M_WR_ADDR_VALID = awvalid_q;
    assign M_WR_STRB       = 4'hF;
    assign M_WR_DATA       = (state_q == WR_DATA) ? wdata_in : 32'd0;
    assign M_WR_DATA_VALID = (state_q == WR_DATA) && wdata_valid;
    assign M_WR_DATA_LAST  = (state_q == WR_DATA) && w_last_beat;
    assign wdata_ready     = (state_q == WR_DATA) && M_WR_DATA_READY;
    assign M_WR_BACK_READY = (state_q == WR_RESP);

    assign M_RD_ADDR_ID    = id_q;
    assign M_RD_ADDR       = addr_q;
    assign M_RD_ADDR_LEN   = len_q;
    assign M_RD_ADDR_BURST = BURST_TYPE;
    assign M_RD_ADDR_VALID = arvalid_q;
    assign M_RD_DATA_READY = (state_q == RD_DATA) && rdata_ready;
    assign rdata_valid     = (state_q == RD_DATA) && M_RD_DATA_VALID;
    assign rdata_out       = (state_q == RD_DATA) ? M_RD_DATA : 32'd0;
    assign rdata_last      = (state_q == RD_DATA) && w_last_beat;

    assign done            = done_q;
    assign done_resp       = done_resp_q;
    assign err_resp        = err_resp_q;
    assign err_timeout     = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_axi_burst_master
// Brief    : Directed bench with a behavioural AXI slave for ddr_axi_burst_master.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_ddr_axi_burst_master;

    localparam int unsigned TO = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [31:0] wdata_in;
    logic        wdata_valid, wdata_ready;
    logic [31:0] rdata_out;
    logic        rdata_last, rdata_valid, rdata_ready;
    logic        done, err_resp, err_timeout, err_clr;
    logic [1:0]  done_resp;
    logic [3:0]  M_WR_ADDR_ID, M_WR_STRB, M_WR_BACK_ID, M_RD_ADDR_ID, M_RD_BACK_ID;
    logic [31:0] M_WR_ADDR, M_WR_DATA, M_RD_ADDR, M_RD_DATA;
    logic [7:0]  M_WR_ADDR_LEN, M_RD_ADDR_LEN;
    logic [1:0]  M_WR_ADDR_BURST, M_WR_BACK_RESP, M_RD_ADDR_BURST, M_RD_DATA_RESP;
    logic        M_WR_ADDR_VALID, M_WR_ADDR_READY, M_WR_DATA_LAST, M_WR_DATA_VALID;
    logic        M_WR_DATA_READY, M_WR_BACK_VALID, M_WR_BACK_READY;
    logic        M_RD_ADDR_VALID, M_RD_ADDR_READY, M_RD_DATA_LAST, M_RD_DATA_VALID, M_RD_DATA_READY;

    always #5 clk = ~clk;

    ddr_axi_burst_master #(.TIMEOUT_CYCLES(TO), .BURST_TYPE(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wdata_in(wdata_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata_out(rdata_out), .rdata_last(rdata_last), .rdata_valid(rdata_valid),
        .rdata_ready(rdata_ready),
        .done(done), .done_resp(done_resp), .err_resp(err_resp),
        .err_timeout(err_timeout), .err_clr(err_clr),
        .M_WR_ADDR_ID(M_WR_ADDR_ID), .M_WR_ADDR(M_WR_ADDR), .M_WR_ADDR_LEN(M_WR_ADDR_LEN),
        .M_WR_ADDR_BURST(M_WR_ADDR_BURST), .M_WR_ADDR_VALID(M_WR_ADDR_VALID),
        .M_WR_ADDR_READY(M_WR_ADDR_READY), .M_WR_DATA(M_WR_DATA), .M_WR_STRB(M_WR_STRB),
        .M_WR_DATA_LAST(M_WR_DATA_LAST), .M_WR_DATA_VALID(M_WR_DATA_VALID),
        .M_WR_DATA_READY(M_WR_DATA_READY), .M_WR_BACK_ID(M_WR_BACK_ID),
        .M_WR_BACK_RESP(M_WR_BACK_RESP), .M_WR_BACK_VALID(M_WR_BACK_VALID),
        .M_WR_BACK_READY(M_WR_BACK_READY),
        .M_RD_ADDR_ID(M_RD_ADDR_ID), .M_RD_ADDR(M_RD_ADDR), .M_RD_ADDR_LEN(M_RD_ADDR_LEN),
        .M_RD_ADDR_BURST(M_RD_ADDR_BURST), .M_RD_ADDR_VALID(M_RD_ADDR_VALID),
        .M_RD_ADDR_READY(M_RD_ADDR_READY), .M_RD_BACK_ID(M_RD_BACK_ID),
        .M_RD_DATA(M_RD_DATA), .M_RD_DATA_RESP(M_RD_DATA_RESP),
        .M_RD_DATA_LAST(M_RD_DATA_LAST), .M_RD_DATA_VALID(M_RD_DATA_VALID),
        .M_RD_DATA_READY(M_RD_DATA_READY)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave knobs and observations
    bit          aw_hold = 0, wr_bp = 0, rlast_flip = 0;
    logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
    logic [3:0]  bid_xor = 4'h0, rid_xor = 4'h0;
    logic [31:0] aw_addr_s = 0, ar_addr_s = 0;
    logic [7:0]  aw_len_s = 0, ar_len_s = 0;
    logic [3:0]  aw_id_s = 0, ar_id_s = 0;
    logic [1:0]  aw_burst_s = 0, ar_burst_s = 0;
    int          w_beats = 0, w_last_bad = 0, w_early = 0, strb_bad = 0;

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];
    logic [31:0] wbuf [256];

    // Behavioural AXI write slave
    initial begin
        int phase;
        int beat;
        phase = 0; beat = 0;
        M_WR_ADDR_READY = 0; M_WR_DATA_READY = 0; M_WR_BACK_VALID = 0;
        M_WR_BACK_ID = 0; M_WR_BACK_RESP = 0;
        forever begin
            @(negedge clk);
            M_WR_ADDR_READY = (phase == 0) && !aw_hold;
            M_WR_DATA_READY = (phase == 1) && (!wr_bp || ($urandom_range(0, 2) != 0));
            M_WR_BACK_VALID = (phase == 2);
            M_WR_BACK_RESP  = bresp_k;
            M_WR_BACK_ID    = aw_id_s ^ bid_xor;
            #1;
            if (!rst_n) begin
                phase = 0; beat = 0;
            end else begin
                if (phase != 1 && M_WR_DATA_VALID) w_early++;
                case (phase)
                    0: if (M_WR_ADDR_VALID && M_WR_ADDR_READY) begin
                        aw_addr_s = M_WR_ADDR; aw_len_s = M_WR_ADDR_LEN;
                        aw_id_s = M_WR_ADDR_ID; aw_burst_s = M_WR_ADDR_BURST;
                        beat = 0; phase = 1;
                    end
                    1: if (M_WR_DATA_VALID && M_WR_DATA_READY) begin
                        slv_mem[aw_addr_s + beat] = M_WR_DATA;
                        if (M_WR_STRB !== 4'hF) strb_bad++;
                        if (M_WR_DATA_LAST !== (beat == int'(aw_len_s))) w_last_bad++;
                        w_beats++;
                        if (beat == int'(aw_len_s)) phase = 2;
                        beat++;
                    end
                    default: if (M_WR_BACK_READY) phase = 0;
                endcase
            end
        end
    end

    // Behavioural AXI read slave
    initial begin
        int rphase;
        int rbeat;
        rphase = 0; rbeat = 0;
        M_RD_ADDR_READY = 0; M_RD_DATA_VALID = 0; M_RD_DATA = 0;
        M_RD_DATA_LAST = 0; M_RD_DATA_RESP = 0; M_RD_BACK_ID = 0;
        forever begin
            @(negedge clk);
            M_RD_ADDR_READY = (rphase == 0);
            M_RD_DATA_VALID = (rphase == 1);
            M_RD_DATA       = slv_mem.exists(ar_addr_s + rbeat) ? slv_mem[ar_addr_s + rbeat] : 32'h0;
            M_RD_DATA_LAST  = (rphase == 1) && (((rbeat == int'(ar_len_s)) ? 1'b1 : 1'b0) ^ rlast_flip);
            M_RD_DATA_RESP  = rresp_k;
            M_RD_BACK_ID    = ar_id_s ^ rid_xor;
            #1;
            if (!rst_n) begin
                rphase = 0; rbeat = 0;
            end else if (rphase == 0) begin
                if (M_RD_ADDR_VALID && M_RD_ADDR_READY) begin
                    ar_addr_s = M_RD_ADDR; ar_len_s = M_RD_ADDR_LEN;
                    ar_id_s = M_RD_ADDR_ID; ar_burst_s = M_RD_ADDR_BURST;
                    rbeat = 0; rphase = 1;
                end
            end else if (M_RD_DATA_READY) begin
                if (rbeat == int'(ar_len_s)) rphase = 0;
                rbeat++;
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
        #1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic run_write(input logic [31:0] a, input int l, input bit bp,
                             output logic [1:0] dresp, output int dcount, output logic err_at_done);
        int i;
        int cyc;
        bit seen;
        i = 0; cyc = 0; seen = 0; dcount = 0; dresp = 2'bxx; err_at_done = 1'bx;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            wdata_valid = (i <= l) && (!bp || ($urandom_range(0, 2) != 0));
            if (i <= l) wdata_in = wbuf[i];
            #1;
            if (wdata_valid && wdata_ready) begin
                exp_mem[a + i] = wdata_in;
                i++;
            end
            if (done) begin seen = 1; dresp = done_resp; err_at_done = err_resp; dcount++; end
            cyc++;
        end
        @(negedge clk);
        wdata_valid = 0;
        #1;
        if (done) dcount++;
    endtask

    task automatic run_read(input logic [31:0] a, input int l, input bit bp,
                            output logic [1:0] dresp, output int dcount, output logic err_at_done,
                            output int nbeats, output int mism, output int lastbad,
                            output logic [31:0] first);
        int cyc;
        bit seen;
        cyc = 0; seen = 0; dcount = 0; dresp = 2'bxx; err_at_done = 1'bx;
        nbeats = 0; mism = 0; lastbad = 0; first = 32'hx;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            rdata_ready = !bp || ($urandom_range(0, 2) != 0);
            #1;
            if (rdata_valid && rdata_ready) begin
                if (nbeats == 0) first = rdata_out;
                if (rdata_out !== exp_mem[a + nbeats]) mism++;
                if (rdata_last !== (nbeats == l)) lastbad++;
                nbeats++;
            end
            if (done) begin seen = 1; dresp = done_resp; err_at_done = err_resp; dcount++; end
            cyc++;
        end
        @(negedge clk);
        rdata_ready = 0;
        #1;
        if (done) dcount++;
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  dr;
        int          dc, nb, mm, lb;
        logic        ed;
        logic [31:0] fd;

        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wdata_in = 0; wdata_valid = 0; rdata_ready = 0; err_clr = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valids", {M_WR_ADDR_VALID, M_RD_ADDR_VALID, M_WR_DATA_VALID, rdata_valid}, 4'b0000);
        check("rst_readys", {M_WR_BACK_READY, M_RD_DATA_READY, wdata_ready, M_WR_DATA_LAST, rdata_last}, 5'b0);
        check("rst_flags", {done, err_resp, err_timeout, done_resp}, 5'b0);
        check("rst_burst", {M_WR_ADDR_BURST, M_RD_ADDR_BURST, M_WR_STRB}, 8'b01_01_1111);
        check("rst_fields", {M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_ID}, 44'd0);
        @(negedge clk);
        rst_n = 1;

        // 4-beat write then readback
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        w_beats = 0; w_last_bad = 0; w_early = 0;
        send_cmd(1'b1, 32'h100, 8'd3, 4'd5);
        run_write(32'h100, 3, 1'b0, dr, dc, ed);
        check("wr4_aw", {aw_addr_s, aw_len_s, aw_burst_s, aw_id_s}, {32'h100, 8'd3, 2'b01, 4'd5});
        check("wr4_beats", w_beats, 4);
        check("wr4_last", w_last_bad, 0);
        check("wr4_early_w", w_early, 0);
        check("wr4_done_cnt", dc, 1);
        check("wr4_done_resp", dr, 2'b00);
        check("wr4_err", err_resp, 1'b0);

        send_cmd(1'b0, 32'h100, 8'd3, 4'd7);
        run_read(32'h100, 3, 1'b0, dr, dc, ed, nb, mm, lb, fd);
        check("rd4_ar", {ar_addr_s, ar_len_s, ar_burst_s, ar_id_s}, {32'h100, 8'd3, 2'b01, 4'd7});
        check("rd4_beats", nb, 4);
        check("rd4_first", fd, 32'hA0);
        check("rd4_data", mm, 0);
        check("rd4_last", lb, 0);
        check("rd4_done", {dc, dr, err_resp}, {32'd1, 2'b00, 1'b0});

        // single-beat bursts
        wbuf[0] = 32'hDEADBEEF;
        w_beats = 0; w_last_bad = 0;
        send_cmd(1'b1, 32'h2000, 8'd0, 4'd1);
        run_write(32'h2000, 0, 1'b0, dr, dc, ed);
        check("wr1_beats", w_beats, 1);
        check("wr1_last", w_last_bad, 0);
        check("wr1_done", {dc, dr}, {32'd1, 2'b00});
        send_cmd(1'b0, 32'h2000, 8'd0, 4'd1);
        run_read(32'h2000, 0, 1'b0, dr, dc, ed, nb, mm, lb, fd);
        check("rd1_data", fd, 32'hDEADBEEF);
        check("rd1_beats_last", {nb, lb, dc}, {32'd1, 32'd0, 32'd1});

        // 256-beat bursts with backpressure on both sides
        for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
        w_beats = 0; w_last_bad = 0; w_early = 0; wr_bp = 1;
        send_cmd(1'b1, 32'h400, 8'd255, 4'd3);
        run_write(32'h400, 255, 1'b1, dr, dc, ed);
        wr_bp = 0;
        check("wr256_len", aw_len_s, 8'd255);
        check("wr256_beats", w_beats, 256);
        check("wr256_last", w_last_bad, 0);
        check("wr256_early_w", w_early, 0);
        check("wr256_done", {dc, dr}, {32'd1, 2'b00});
        send_cmd(1'b0, 32'h400, 8'd255, 4'd3);
        run_read(32'h400, 255, 1'b1, dr, dc, ed, nb, mm, lb, fd);
        check("rd256_beats", nb, 256);
        check("rd256_data", mm, 0);
        check("rd256_last", lb, 0);
        check("rd256_done", {dc, err_resp}, {32'd1, 1'b0});

        // response and ID errors
        wbuf[0] = 32'h1234_5678;
        bresp_k = 2'b10;
        send_cmd(1'b1, 32'h10, 8'd0, 4'd5);
        run_write(32'h10, 0, 1'b0, dr, dc, ed);
        bresp_k = 2'b00;
        check("bresp_done_resp", dr, 2'b10);
        check("bresp_err", err_resp, 1'b1);
        send_cmd(1'b1, 32'h10, 8'd0, 4'd5);
        run_write(32'h10, 0, 1'b0, dr, dc, ed);
        check("err_sticky", {dr, err_resp}, {2'b00, 1'b1});
        pulse_clr();
        check("err_clr", err_resp, 1'b0);
        bid_xor = 4'h6;
        send_cmd(1'b1, 32'h10, 8'd0, 4'd5);
        run_write(32'h10, 0, 1'b0, dr, dc, ed);
        bid_xor = 4'h0;
        check("bid_err", {dr, err_resp}, {2'b00, 1'b1});
        // clear held across a fresh error: the set must win
        @(negedge clk); err_clr = 1;
        bresp_k = 2'b10;
        send_cmd(1'b1, 32'h10, 8'd0, 4'd5);
        run_write(32'h10, 0, 1'b0, dr, dc, ed);
        bresp_k = 2'b00;
        check("set_wins", ed, 1'b1);
        @(negedge clk); err_clr = 0; #1;
        check("clr_after_set", err_resp, 1'b0);

        rresp_k = 2'b01;
        send_cmd(1'b0, 32'h100, 8'd3, 4'd7);
        run_read(32'h100, 3, 1'b0, dr, dc, ed, nb, mm, lb, fd);
        rresp_k = 2'b00;
        check("rresp_done_resp", dr, 2'b01);
        check("rresp_err", err_resp, 1'b1);
        pulse_clr();
        rlast_flip = 1;
        send_cmd(1'b0, 32'h100, 8'd3, 4'd7);
        run_read(32'h100, 3, 1'b0, dr, dc, ed, nb, mm, lb, fd);
        rlast_flip = 0;
        check("rlast_beats", {nb, mm, lb}, {32'd4, 32'd0, 32'd0});
        check("rlast_err", {dr, err_resp}, {2'b00, 1'b1});
        pulse_clr();

        // AW stall beyond the timeout
        aw_hold = 1;
        send_cmd(1'b1, 32'h3000, 8'd0, 4'd9);
        repeat (TO - 20) @(negedge clk);
        #1;
        check("to_before", {err_timeout, M_WR_ADDR_VALID}, 2'b01);
        repeat (30) @(negedge clk);
        #1;
        check("to_after", {err_timeout, M_WR_ADDR_VALID}, 2'b11);
        check("to_fields", {M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_ID}, {32'h3000, 8'd0, 4'd9});
        aw_hold = 0;
        wbuf[0] = 32'hCAFE_F00D;
        run_write(32'h3000, 0, 1'b0, dr, dc, ed);
        check("to_complete", {dc, err_timeout}, {32'd1, 1'b1});

        // reset in the middle of a read burst
        send_cmd(1'b0, 32'h400, 8'd255, 4'd2);
        repeat (5) @(negedge clk);
        #1;
        check("mid_rd_valid", rdata_valid, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_valids", {rdata_valid, M_RD_DATA_READY, M_RD_ADDR_VALID, M_WR_ADDR_VALID, rdata_last}, 5'b0);
        check("rst_mid_flags", {done, err_resp, err_timeout, cmd_ready}, 4'b0001);
        repeat (3) @(negedge clk);
        rst_n = 1;
        send_cmd(1'b0, 32'h2000, 8'd0, 4'd4);
        run_read(32'h2000, 0, 1'b0, dr, dc, ed, nb, mm, lb, fd);
        check("post_rst_read", {fd, nb, dc}, {32'hDEADBEEF, 32'd1, 32'd1});
        check("strb_all", strb_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
